afe_config_sequencer: RTL and testbench
=======================================

# afe_config_sequencer

Walks the AFE configuration command ROM from address 0 on `start` and executes each 24-bit word. The word splits into a 4-bit command and 20-bit data; supported commands are serial shift, timed wait, AFE reset pulse and end. It sits between the command ROM (1-cycle registered read) and the AFE serial configuration pins, and reports busy/done/error to system control.

## Interface
- `CLK_DIV`, default 4: system clocks per SCLK half-period; legal range ≥ 2.
- `clk` input 1: system clock; everything is rising-edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: one-cycle pulse; begins a run at ROM address 0.
- `rom_address` output 8: address to the command ROM.
- `controller_command` input 4: ROM word [23:20], valid one cycle after `rom_address` changes.
- `afe_shift_data` input 20: ROM word [19:0], same timing as `controller_command`.
- `afe_sclk` output 1: serial clock; idles low.
- `afe_sdata` output 1: serial data, MSB first.
- `afe_sen_n` output 1: serial enable, active low.
- `afe_reset` output 1: active-high AFE reset pulse.
- `busy` output 1: high from the cycle after an accepted `start` until the run terminates.
- `done` output 1: one-cycle pulse on an END terminate.
- `error` output 1: sticky; cleared by the next accepted `start` or by `reset`.

## Operation
- Commands:
  - 0x0 NOP.
  - 0x1 SHIFT: send data[19:0].
  - 0x2 WAIT: hold for data[19:0] cycles.
  - 0x3 RESET: pulse `afe_reset` for data[19:0] cycles.
  - 0xF END.
  - Any other command is illegal: the run terminates with `error`=1 and no `done`.
- States: IDLE, FETCH, EXEC, SHIFT, WAIT, PULSE, FINISH.
  - IDLE: a `start` sets `rom_address`=0 and clears `error`, then goes to FETCH. `start` while `busy` is ignored.
  - FETCH: waits one cycle for ROM read latency, then goes to EXEC.
  - EXEC: samples command/data.
    - NOP, or WAIT/RESET with data=0: increment the address and go to FETCH.
    - SHIFT goes to SHIFT; WAIT goes to WAIT; RESET goes to PULSE.
    - END or illegal goes to FINISH.
  - SHIFT/WAIT/PULSE: on completion, increment the address and go to FETCH.
  - FINISH: drops `busy`, pulses `done` (END only), returns to IDLE. `rom_address` holds its last value.
- Address end: if EXEC at address 255 is not END, the run terminates with `error` after executing that word. Address never wraps to 0 within a run.
- SHIFT frame:
  - `afe_sen_n` falls, then `CLK_DIV` setup cycles.
  - 20 bits follow. Each bit drives `afe_sdata` while `afe_sclk` is low for `CLK_DIV` cycles, then `afe_sclk` is high for `CLK_DIV` cycles; the AFE samples on the rising edge.
  - After the last falling edge: `CLK_DIV` hold cycles, then `afe_sen_n` rises.
  - Then `CLK_DIV` cycles of `afe_sen_n` high before leaving SHIFT.
- WAIT and PULSE use a 20-bit down-counter loaded in EXEC with data. `afe_reset` is high for exactly data cycles.
- Reset values: `rom_address`=0, `afe_sclk`=0, `afe_sdata`=0, `afe_sen_n`=1, `afe_reset`=0, `busy`=0, `done`=0, `error`=0; state IDLE.
- Reset mid-run: all outputs take their reset values on the next edge, including aborting a SHIFT frame (`afe_sen_n` high immediately). No `done` pulse.

## Timing
- `start` accepted at edge 0; `busy`=1 and `rom_address`=0 after edge 0; EXEC of word 0 at edge 2.
- Per-word overhead is 2 cycles (FETCH+EXEC). NOP word: 2 cycles. WAIT N: 2+N. RESET N: 2+N.
- SHIFT word: 2 + `CLK_DIV`×(1+40+1+1) cycles; with `CLK_DIV`=4 that is 174 cycles.
- `done` asserts on the same edge `busy` falls: one cycle after EXEC of END.
- All outputs are registered; no combinational paths from inputs to outputs.

## Structure
- Shared package `afe_config_pkg`:
  - command encodings `CMD_NOP`, `CMD_SHIFT`, `CMD_WAIT`, `CMD_RESET`, `CMD_END`.
  - widths `AFE_CMD_W`=4, `AFE_DATA_W`=20, `AFE_ROM_AW`=8.
  - state enum.
- Sub-module `afe_serial_shifter` owns the frame and SCLK divider.
  - Inputs: `load`, 20-bit word.
  - Outputs: `afe_sclk`, `afe_sdata`, `afe_sen_n`, `shift_done` pulse.
  - The sequencer owns the FSM, address counter and wait/pulse counter.

## Test plan
- ROM {0x1ABCDE, 0xF00000}, `CLK_DIV`=4, `start` → one frame shifting 0xABCDE MSB first (first bit 1, last bit 0), 20 SCLK rising edges; `done` at cycle 177 after `start`; `error`=0.
- ROM {0x200010, 0x300005, 0xF00000} → `afe_reset` high exactly 5 cycles, starting 20 cycles after `start`; `afe_sen_n` stays 1.
- ROM {0x000000, 0x700000} → `error`=1, no `done`, `busy` falls 5 cycles after `start`; next `start` clears `error`.
- ROM all 0x000000 (no END) → addresses 0..255 visited once, `error`=1 after address 255, `rom_address` holds 255.
- `reset` asserted mid-frame (bit 7 of a SHIFT) → next cycle `afe_sen_n`=1, `afe_sclk`=0, `busy`=0, `rom_address`=0; a new `start` reruns from word 0.
- `start` pulsed while `busy` → ignored; the run's address sequence and `done` timing are unchanged.

Source files
------------

// File: rtl/afe_config_pkg.sv
// Shared encodings, widths and state types for the AFE configuration sequencer.
package afe_config_pkg;

  localparam int AFE_CMD_W  = 4;
  localparam int AFE_DATA_W = 20;
  localparam int AFE_ROM_AW = 8;

  localparam logic [AFE_CMD_W-1:0] CMD_NOP   = 4'h0;
  localparam logic [AFE_CMD_W-1:0] CMD_SHIFT = 4'h1;
  localparam logic [AFE_CMD_W-1:0] CMD_WAIT  = 4'h2;
  localparam logic [AFE_CMD_W-1:0] CMD_RESET = 4'h3;
  localparam logic [AFE_CMD_W-1:0] CMD_END   = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_PULSE  = 3'd5,
    ST_FINISH = 3'd6
  } afe_state_e;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_SETUP = 3'd1,
    PH_BITS  = 3'd2,
    PH_HOLD  = 3'd3,
    PH_GAP   = 3'd4
  } shift_phase_e;

endpackage

// File: rtl/afe_serial_shifter.sv
// Serial frame generator: SEN_N framing, SCLK divider and MSB-first data shift.
module afe_serial_shifter
  import afe_config_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  load_i,
  input  logic [AFE_DATA_W-1:0] word_i,
  output logic                  afe_sclk_o,
  output logic                  afe_sdata_o,
  output logic                  afe_sen_n_o,
  output logic                  shift_done_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  shift_phase_e          phase_q, phase_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [4:0]            bit_q, bit_d;
  logic [AFE_DATA_W-1:0] sr_q, sr_d;
  logic                  sclk_q, sclk_d;
  logic                  sen_n_q, sen_n_d;
  logic                  div_last_s;

  assign div_last_s   = (div_q == DIV_W'(CLK_DIV - 1));
  assign afe_sclk_o   = sclk_q;
  assign afe_sdata_o  = sr_q[AFE_DATA_W-1];
  assign afe_sen_n_o  = sen_n_q;
  assign shift_done_o = (phase_q == PH_GAP) && div_last_s;

  // Frame phase sequencing; every phase lasts a multiple of CLK_DIV cycles.
  always_comb begin
    phase_d = phase_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    sclk_d  = sclk_q;
    sen_n_d = sen_n_q;
    if (phase_q == PH_IDLE) begin
      div_d = '0;
    end else begin
      div_d = div_last_s ? '0 : div_q + DIV_W'(1);
    end
    case (phase_q)
      PH_IDLE: begin
        if (load_i) begin
          phase_d = PH_SETUP;
          bit_d   = 5'd0;
          sr_d    = word_i;
          sclk_d  = 1'b0;
          sen_n_d = 1'b0;
        end else begin
          phase_d = PH_IDLE;
        end
      end
      PH_SETUP: begin
        if (div_last_s) begin
          phase_d = PH_BITS;
        end else begin
          phase_d = PH_SETUP;
        end
      end
      PH_BITS: begin
        if (!div_last_s) begin
          phase_d = PH_BITS;
        end else if (!sclk_q) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d = 1'b0;
          // The last bit stays on SDATA through the hold window.
          if (bit_q == 5'(AFE_DATA_W - 1)) begin
            phase_d = PH_HOLD;
          end else begin
            bit_d = bit_q + 5'd1;
            sr_d  = {sr_q[AFE_DATA_W-2:0], 1'b0};
          end
        end
      end
      PH_HOLD: begin
        if (div_last_s) begin
          sen_n_d = 1'b1;
          phase_d = PH_GAP;
        end else begin
          phase_d = PH_HOLD;
        end
      end
      PH_GAP: begin
        if (div_last_s) begin
          phase_d = PH_IDLE;
        end else begin
          phase_d = PH_GAP;
        end
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  // Shifter state registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      phase_q <= PH_IDLE;
      div_q   <= '0;
      bit_q   <= 5'd0;
      sr_q    <= '0;
      sclk_q  <= 1'b0;
      sen_n_q <= 1'b1;
    end else begin
      phase_q <= phase_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      sclk_q  <= sclk_d;
      sen_n_q <= sen_n_d;
    end
  end

endmodule

// File: rtl/afe_config_sequencer.sv
// Walks the AFE command ROM from address 0 and executes NOP/SHIFT/WAIT/RESET/END words.
module afe_config_sequencer
  import afe_config_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [AFE_ROM_AW-1:0] rom_address,
  input  logic [AFE_CMD_W-1:0]  controller_command,
  input  logic [AFE_DATA_W-1:0] afe_shift_data,
  output logic                  afe_sclk,
  output logic                  afe_sdata,
  output logic                  afe_sen_n,
  output logic                  afe_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  afe_state_e            state_q, state_d, adv_state_s;
  logic [AFE_ROM_AW-1:0] addr_q, addr_d, adv_addr_s;
  logic [AFE_DATA_W-1:0] cnt_q, cnt_d;
  logic                  busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic                  afe_reset_q, afe_reset_d, term_err_q, term_err_d, adv_err_s;
  logic                  load_s, shift_done_s, cnt_last_s;

  assign rom_address = addr_q;
  assign afe_reset   = afe_reset_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign cnt_last_s  = (cnt_q == AFE_DATA_W'(1));

  // Moving past address 255 ends the run with an error instead of wrapping.
  always_comb begin
    if (addr_q == {AFE_ROM_AW{1'b1}}) begin
      adv_state_s = ST_FINISH;
      adv_addr_s  = addr_q;
      adv_err_s   = 1'b1;
    end else begin
      adv_state_s = ST_FETCH;
      adv_addr_s  = addr_q + AFE_ROM_AW'(1);
      adv_err_s   = term_err_q;
    end
  end

  // Sequencer next-state and output decode.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    afe_reset_d = afe_reset_q;
    term_err_d  = term_err_q;
    load_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d     = '0;
          error_d    = 1'b0;
          term_err_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        case (controller_command)
          CMD_NOP: begin
            state_d = adv_state_s; addr_d = adv_addr_s; term_err_d = adv_err_s;
          end
          CMD_SHIFT: begin
            load_s  = 1'b1;
            state_d = ST_SHIFT;
          end
          CMD_WAIT, CMD_RESET: begin
            if (afe_shift_data == '0) begin
              state_d = adv_state_s; addr_d = adv_addr_s; term_err_d = adv_err_s;
            end else begin
              cnt_d       = afe_shift_data;
              afe_reset_d = (controller_command == CMD_RESET);
              state_d     = (controller_command == CMD_RESET) ? ST_PULSE : ST_WAIT;
            end
          end
          CMD_END: begin
            term_err_d = 1'b0;
            state_d    = ST_FINISH;
          end
          default: begin
            term_err_d = 1'b1;
            state_d    = ST_FINISH;
          end
        endcase
      end
      ST_SHIFT: begin
        if (shift_done_s) begin
          state_d = adv_state_s; addr_d = adv_addr_s; term_err_d = adv_err_s;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_WAIT, ST_PULSE: begin
        if (cnt_last_s) begin
          afe_reset_d = 1'b0;
          state_d = adv_state_s; addr_d = adv_addr_s; term_err_d = adv_err_s;
        end else begin
          cnt_d = cnt_q - AFE_DATA_W'(1);
        end
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        done_d  = ~term_err_q;
        error_d = error_q | term_err_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      afe_reset_q <= 1'b0;
      term_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      afe_reset_q <= afe_reset_d;
      term_err_q  <= term_err_d;
    end
  end

  afe_serial_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk_i       (clk),
    .reset_i     (reset),
    .load_i      (load_s),
    .word_i      (afe_shift_data),
    .afe_sclk_o  (afe_sclk),
    .afe_sdata_o (afe_sdata),
    .afe_sen_n_o (afe_sen_n),
    .shift_done_o(shift_done_s)
  );

endmodule

// File: tb/tb_afe_config_sequencer.sv
// Self-checking bench: directed scenarios plus random ROM programs against a timeline model.
module tb_afe_config_sequencer;

  localparam int CLK_DIV   = 4;
  localparam int FRAME_CYC = 43 * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rom_address;
  logic [3:0]  controller_command;
  logic [19:0] afe_shift_data;
  logic        afe_sclk, afe_sdata, afe_sen_n, afe_reset, busy, done, error;

  logic [23:0] rom [256];
  logic [23:0] rom_q = 24'h0;

  int n_checks = 0;
  int n_fail   = 0;
  int posedge_count = 0;
  int start_pc = 0;
  bit mon_en = 1'b0;

  // Observations gathered by the monitor, relative to the start edge.
  int obs_fall, obs_done_cnt, obs_done_rel, obs_err_start, obs_err_end;
  int obs_last, obs_addr_chg, obs_addr_bad, obs_sclk_bad, obs_sen_low_total;
  int obs_frames[$], obs_fbits[$], obs_senlow[$], obs_pst[$], obs_plen[$];
  int cur_word, cur_bits, cur_senlow, cur_pst, cur_plen;
  logic prev_busy, prev_rst, prev_sclk, prev_sen;
  logic [7:0] prev_addr;

  // Expectations from the reference model.
  int exp_fall, exp_done_cnt, exp_done_rel, exp_err, exp_last;
  int exp_frames[$], exp_pst[$], exp_plen[$];

  afe_config_sequencer #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .rom_address(rom_address),
    .controller_command(controller_command), .afe_shift_data(afe_shift_data),
    .afe_sclk(afe_sclk), .afe_sdata(afe_sdata), .afe_sen_n(afe_sen_n),
    .afe_reset(afe_reset), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) posedge_count <= posedge_count + 1;
  always @(posedge clk) rom_q <= rom[rom_address];
  assign controller_command = rom_q[23:20];
  assign afe_shift_data     = rom_q[19:0];

  always @(negedge clk) begin
    int rel;
    rel = posedge_count - start_pc;
    if (mon_en && rel >= 0) begin
      if (rel == 0) obs_err_start = error;
      if (prev_busy && !busy && obs_fall < 0) obs_fall = rel;
      if (done) begin obs_done_cnt++; obs_done_rel = rel; end
      if (afe_reset && !prev_rst) begin cur_pst = rel; cur_plen = 0; end
      if (afe_reset) cur_plen++;
      if (!afe_reset && prev_rst) begin obs_pst.push_back(cur_pst); obs_plen.push_back(cur_plen); end
      if (!afe_sen_n) begin cur_senlow++; obs_sen_low_total++; end
      if (afe_sclk && afe_sen_n) obs_sclk_bad++;
      if (afe_sclk && !prev_sclk && !afe_sen_n) begin
        cur_word = ((cur_word << 1) | int'(afe_sdata)) & 32'hFFFFF;
        cur_bits++;
      end
      if (afe_sen_n && !prev_sen) begin
        obs_frames.push_back(cur_word); obs_fbits.push_back(cur_bits); obs_senlow.push_back(cur_senlow);
        cur_word = 0; cur_bits = 0; cur_senlow = 0;
      end
      if (rom_address != prev_addr) begin
        obs_addr_chg++;
        if (rom_address != prev_addr + 8'd1) obs_addr_bad++;
      end
      obs_last  = rom_address;
      prev_busy = busy; prev_rst = afe_reset; prev_sclk = afe_sclk;
      prev_sen  = afe_sen_n; prev_addr = rom_address;
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 24'h0;
  endtask

  // Timeline model: word w starts at cycle t, EXEC resolves at t+2.
  task automatic model();
    int t;
    bit fin;
    int cmd, d, ex;
    t = 0; fin = 1'b0;
    exp_frames.delete(); exp_pst.delete(); exp_plen.delete();
    exp_done_cnt = 0; exp_done_rel = -1; exp_err = 0; exp_fall = -1; exp_last = 0;
    for (int a = 0; a < 256 && !fin; a++) begin
      cmd = int'(rom[a][23:20]); d = int'(rom[a][19:0]); ex = t + 2; exp_last = a;
      if (cmd == 15) begin
        exp_done_cnt = 1; exp_done_rel = ex + 1; exp_fall = ex + 1; fin = 1'b1;
      end else if (cmd > 3) begin
        exp_err = 1; exp_fall = ex + 1; fin = 1'b1;
      end else begin
        if (cmd == 0) t = ex;
        else if (cmd == 1) begin exp_frames.push_back(d); t = ex + FRAME_CYC; end
        else begin
          if (cmd == 3 && d > 0) begin exp_pst.push_back(ex); exp_plen.push_back(d); end
          t = ex + d;
        end
        if (a == 255) begin exp_err = 1; exp_fall = t + 1; fin = 1'b1; end
      end
    end
  endtask

  task automatic run_program(input int extra_start_rel, input int budget);
    obs_fall = -1; obs_done_cnt = 0; obs_done_rel = -1; obs_err_start = -1; obs_err_end = -1;
    obs_last = 0; obs_addr_chg = 0; obs_addr_bad = 0; obs_sclk_bad = 0; obs_sen_low_total = 0;
    obs_frames.delete(); obs_fbits.delete(); obs_senlow.delete(); obs_pst.delete(); obs_plen.delete();
    cur_word = 0; cur_bits = 0; cur_senlow = 0; cur_pst = 0; cur_plen = 0;
    prev_busy = 1'b0; prev_rst = 1'b0; prev_sclk = 1'b0; prev_sen = 1'b1; prev_addr = 8'd0;
    @(negedge clk);
    start = 1'b1; start_pc = posedge_count + 1; mon_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < budget && obs_fall < 0; c++) begin
      @(negedge clk);
      start = (posedge_count - start_pc == extra_start_rel);
    end
    start = 1'b0;
    if (obs_fall < 0) begin
      n_checks++; n_fail++;
      $display("FAIL run_timeout: busy still high after %0d cycles, required to fall", budget);
    end
    repeat (3) @(negedge clk);
    obs_err_end = error;
    mon_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rom_address, afe_sclk, afe_sdata, afe_sen_n, afe_reset, busy, done, error} !== {8'd0, 7'b0010000}) begin
      n_fail++;
      $display("FAIL reset_values: got addr=%0d sclk=%b sdata=%b sen_n=%b rst=%b busy=%b done=%b err=%b, required 0/0/0/1/0/0/0/0",
               rom_address, afe_sclk, afe_sdata, afe_sen_n, afe_reset, busy, done, error);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_shift_end();
    clear_rom(); rom[0] = 24'h1ABCDE; rom[1] = 24'hF00000;
    run_program(-1, 400);
    n_checks++;
    if (obs_frames.size() != 1 || obs_frames[0] !== 'hABCDE || obs_fbits[0] != 20) begin
      n_fail++;
      $display("FAIL shift_frame: got %0d frames first=%h bits=%0d, required 1 frame abcde with 20 bits",
               obs_frames.size(), (obs_frames.size() > 0) ? obs_frames[0] : 0, (obs_fbits.size() > 0) ? obs_fbits[0] : 0);
    end
    n_checks++;
    if (obs_senlow.size() != 1 || obs_senlow[0] != 42 * CLK_DIV) begin
      n_fail++;
      $display("FAIL shift_sen_window: got %0d, required %0d", (obs_senlow.size() > 0) ? obs_senlow[0] : -1, 42 * CLK_DIV);
    end
    n_checks++;
    if (obs_done_cnt != 1 || obs_done_rel != 177 || obs_fall != 177) begin
      n_fail++;
      $display("FAIL shift_done_time: got done_cnt=%0d done=%0d fall=%0d, required 1/177/177", obs_done_cnt, obs_done_rel, obs_fall);
    end
    n_checks++;
    if (obs_err_end != 0 || obs_sclk_bad != 0) begin
      n_fail++;
      $display("FAIL shift_err: got error=%0d sclk_outside_frame=%0d, required 0/0", obs_err_end, obs_sclk_bad);
    end
  endtask

  task automatic test_wait_pulse();
    clear_rom(); rom[0] = 24'h200010; rom[1] = 24'h300005; rom[2] = 24'hF00000;
    run_program(-1, 200);
    n_checks++;
    if (obs_pst.size() != 1 || obs_pst[0] != 20 || obs_plen[0] != 5) begin
      n_fail++;
      $display("FAIL pulse_window: got %0d pulses start=%0d len=%0d, required 1 pulse start 20 len 5",
               obs_pst.size(), (obs_pst.size() > 0) ? obs_pst[0] : -1, (obs_plen.size() > 0) ? obs_plen[0] : -1);
    end
    n_checks++;
    if (obs_sen_low_total != 0 || obs_done_rel != 28 || obs_done_cnt != 1) begin
      n_fail++;
      $display("FAIL wait_pulse_run: got sen_low=%0d done=%0d cnt=%0d, required 0/28/1", obs_sen_low_total, obs_done_rel, obs_done_cnt);
    end
  endtask

  task automatic test_illegal();
    clear_rom(); rom[0] = 24'h000000; rom[1] = 24'h700000;
    run_program(-1, 100);
    n_checks++;
    if (obs_err_end != 1 || obs_done_cnt != 0 || obs_fall != 5) begin
      n_fail++;
      $display("FAIL illegal_cmd: got error=%0d done_cnt=%0d fall=%0d, required 1/0/5", obs_err_end, obs_done_cnt, obs_fall);
    end
    clear_rom(); rom[0] = 24'hF00000;
    run_program(-1, 100);
    n_checks++;
    if (obs_err_start != 0 || obs_err_end != 0 || obs_done_rel != 3) begin
      n_fail++;
      $display("FAIL error_clear: got err_at_start=%0d err_end=%0d done=%0d, required 0/0/3", obs_err_start, obs_err_end, obs_done_rel);
    end
  endtask

  task automatic test_no_end();
    clear_rom();
    run_program(-1, 700);
    n_checks++;
    if (obs_fall != 513 || obs_err_end != 1 || obs_done_cnt != 0) begin
      n_fail++;
      $display("FAIL no_end_term: got fall=%0d error=%0d done_cnt=%0d, required 513/1/0", obs_fall, obs_err_end, obs_done_cnt);
    end
    n_checks++;
    if (obs_last != 255 || obs_addr_chg != 255 || obs_addr_bad != 0) begin
      n_fail++;
      $display("FAIL no_end_addr: got last=%0d changes=%0d bad_steps=%0d, required 255/255/0", obs_last, obs_addr_chg, obs_addr_bad);
    end
  endtask

  task automatic test_reset_mid_frame();
    int guard;
    clear_rom(); rom[0] = 24'h000000; rom[1] = 24'h1FFFFF; rom[2] = 24'hF00000;
    @(negedge clk);
    start = 1'b1; start_pc = posedge_count + 1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (posedge_count - start_pc < 66 && guard < 200) begin @(negedge clk); guard++; end
    n_checks++;
    if (afe_sen_n !== 1'b0 || rom_address !== 8'd1) begin
      n_fail++;
      $display("FAIL mid_frame_setup: got sen_n=%b addr=%0d, required 0/1", afe_sen_n, rom_address);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({afe_sen_n, afe_sclk, busy, done, afe_reset} !== 5'b10000 || rom_address !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_frame_reset: got sen_n=%b sclk=%b busy=%b done=%b rst=%b addr=%0d, required 1/0/0/0/0/0",
               afe_sen_n, afe_sclk, busy, done, afe_reset, rom_address);
    end
    run_program(-1, 400);
    n_checks++;
    if (obs_frames.size() != 1 || obs_frames[0] !== 'hFFFFF || obs_done_rel != 179) begin
      n_fail++;
      $display("FAIL rerun_after_reset: got frames=%0d done=%0d, required 1 frame fffff done 179", obs_frames.size(), obs_done_rel);
    end
  endtask

  task automatic test_start_while_busy();
    clear_rom(); rom[0] = 24'h15A5A5; rom[1] = 24'h000000; rom[2] = 24'hF00000;
    run_program(100, 400);
    n_checks++;
    if (obs_done_cnt != 1 || obs_done_rel != 179 || obs_addr_chg != 2 || obs_addr_bad != 0) begin
      n_fail++;
      $display("FAIL start_while_busy: got done_cnt=%0d done=%0d changes=%0d bad=%0d, required 1/179/2/0",
               obs_done_cnt, obs_done_rel, obs_addr_chg, obs_addr_bad);
    end
  endtask

  task automatic test_random();
    int n, sel;
    bit same;
    for (int it = 0; it < 15; it++) begin
      clear_rom();
      n = $urandom_range(0, 5);
      for (int a = 0; a < n; a++) begin
        sel = $urandom_range(0, 3);
        case (sel)
          0: rom[a] = 24'h000000;
          1: rom[a] = {4'h1, 20'($urandom)};
          2: rom[a] = {4'h2, 20'($urandom_range(0, 25))};
          default: rom[a] = {4'h3, 20'($urandom_range(0, 12))};
        endcase
      end
      if ($urandom_range(0, 3) == 0) rom[n] = {4'($urandom_range(4, 14)), 20'($urandom)};
      else rom[n] = 24'hF00000;
      model();
      run_program(-1, 2000);
      n_checks++;
      if (obs_fall != exp_fall || obs_done_cnt != exp_done_cnt || obs_done_rel != exp_done_rel) begin
        n_fail++;
        $display("FAIL rand_timing[%0d]: got fall=%0d done_cnt=%0d done=%0d, required %0d/%0d/%0d",
                 it, obs_fall, obs_done_cnt, obs_done_rel, exp_fall, exp_done_cnt, exp_done_rel);
      end
      n_checks++;
      if (obs_err_end != exp_err || obs_err_start != 0 || obs_last != exp_last || obs_addr_bad != 0) begin
        n_fail++;
        $display("FAIL rand_status[%0d]: got err=%0d err0=%0d last=%0d bad=%0d, required %0d/0/%0d/0",
                 it, obs_err_end, obs_err_start, obs_last, obs_addr_bad, exp_err, exp_last);
      end
      same = (obs_frames.size() == exp_frames.size());
      for (int k = 0; k < obs_frames.size() && same; k++)
        same = (obs_frames[k] == exp_frames[k]) && (obs_fbits[k] == 20) && (obs_senlow[k] == 42 * CLK_DIV);
      n_checks++;
      if (!same || obs_sclk_bad != 0) begin
        n_fail++;
        $display("FAIL rand_frames[%0d]: got %0d frames (sclk_bad=%0d), required %0d frames of 20 bits",
                 it, obs_frames.size(), obs_sclk_bad, exp_frames.size());
      end
      same = (obs_pst.size() == exp_pst.size());
      for (int k = 0; k < obs_pst.size() && same; k++)
        same = (obs_pst[k] == exp_pst[k]) && (obs_plen[k] == exp_plen[k]);
      n_checks++;
      if (!same) begin
        n_fail++;
        $display("FAIL rand_pulses[%0d]: got %0d pulses, required %0d with matching start/length",
                 it, obs_pst.size(), exp_pst.size());
      end
    end
  endtask

  initial begin
    clear_rom();
    test_reset();
    test_shift_end();
    test_wait_pulse();
    test_illegal();
    test_no_end();
    test_reset_mid_frame();
    test_start_while_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
